// File: rtl/pmu_pkg.sv
// pmu_pkg: state encoding and default timing constants shared by the power sequencer.
package pmu_pkg;
   typedef enum logic [2:0] {
      S_EFUSE = 3'd0,
      S_STBY  = 3'd1,
      S_PWRUP = 3'd2,
      S_RUN   = 3'd3,
      S_PWRDN = 3'd4
   } pmu_state_e;
   localparam int EFUSE_TMO_DEF = 64;
   localparam int DN_GAP_DEF    = 2;
endpackage

// File: rtl/pmu_dncnt.sv
// pmu_dncnt: loadable 8-bit down-counter that saturates at zero.
module pmu_dncnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ld,
   input  logic [7:0] i_val,
   input  logic       i_dec,
   output logic [7:0] o_cnt,
   output logic       o_zero
);
   logic [7:0] r_cnt;
   always_ff @(posedge clk)
      if (rst) r_cnt <= '0;
      else if (i_ld) r_cnt <= i_val;
      else if (i_dec && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == 8'd0);
endmodule

// File: rtl/pmu_seq.sv
// pmu_seq: always-on power sequencer (efuse load, AFE power-up/settle, ordered power-down).
module pmu_seq
   import pmu_pkg::*;
#(
   parameter int EFUSE_TMO = EFUSE_TMO_DEF,
   parameter int DN_GAP    = DN_GAP_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rg_top_start,
   input  logic [7:0] rg_settle,
   input  logic       efuse_done,
   output logic       efuse_load_state,
   output logic       afe_clk_en,
   output logic       slot_clk_en,
   output logic       data_clk_en,
   output logic       timer_clk_en,
   output logic       shut_rstn,
   output logic       pmu_fifo_rstn,
   output logic       efuse_err,
   output logic [2:0] pmu_state
);
   // EFUSE loads TMO-2 one cycle after reset so the timeout lands on cycle EFUSE_TMO
   localparam logic [7:0] TMO_LD = 8'(EFUSE_TMO - 2);
   localparam logic [7:0] GAP_LD = 8'(DN_GAP > 1 ? DN_GAP - 1 : 0);
   pmu_state_e r_st;
   logic       r_arm;
   logic       w_ld, w_dec, w_zero;
   logic [7:0] w_val, w_cnt;
   always_comb begin
      w_ld  = (r_st == S_EFUSE && !r_arm) || (r_st == S_STBY && rg_top_start) ||
              ((r_st == S_PWRUP || r_st == S_RUN) && !rg_top_start);
      w_val = r_st == S_EFUSE ? TMO_LD : r_st == S_STBY ? rg_settle : GAP_LD;
      w_dec = r_st == S_EFUSE || r_st == S_PWRUP || r_st == S_PWRDN;
   end
   pmu_dncnt u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_ld   (w_ld),
      .i_val  (w_val),
      .i_dec  (w_dec),
      .o_cnt  (w_cnt),
      .o_zero (w_zero)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st             <= S_EFUSE;
         r_arm            <= 1'b0;
         efuse_load_state <= 1'b1;
         afe_clk_en       <= 1'b0;
         slot_clk_en      <= 1'b0;
         data_clk_en      <= 1'b0;
         timer_clk_en     <= 1'b0;
         shut_rstn        <= 1'b0;
         pmu_fifo_rstn    <= 1'b0;
         efuse_err        <= 1'b0;
      end else begin
         case (r_st)
            S_EFUSE: begin
               r_arm <= 1'b1;
               if (efuse_done || (r_arm && w_zero)) begin
                  r_st             <= S_STBY;
                  efuse_load_state <= 1'b0;
                  efuse_err        <= !efuse_done;
               end
            end
            S_STBY: if (rg_top_start) begin
               r_st       <= S_PWRUP;
               shut_rstn  <= 1'b1;
               afe_clk_en <= 1'b1;
            end
            S_PWRUP, S_RUN: if (!rg_top_start) begin
               r_st          <= S_PWRDN;
               slot_clk_en   <= 1'b0;
               data_clk_en   <= 1'b0;
               timer_clk_en  <= 1'b0;
               pmu_fifo_rstn <= 1'b0;
            end else if (r_st == S_PWRUP && w_zero) begin
               r_st          <= S_RUN;
               slot_clk_en   <= 1'b1;
               data_clk_en   <= 1'b1;
               timer_clk_en  <= 1'b1;
               pmu_fifo_rstn <= 1'b1;
            end
            // AFE clock goes off after the gap, shut reset one cycle later
            S_PWRDN: if (!afe_clk_en) begin
               r_st      <= S_STBY;
               shut_rstn <= 1'b0;
            end else if (w_zero) afe_clk_en <= 1'b0;
            default: r_st <= S_EFUSE;
         endcase
      end
   end
   assign pmu_state = r_st;
endmodule

// File: tb/tb_pmu_seq.sv
// tb_pmu_seq: directed self-checking bench for the power sequencer.
module tb_pmu_seq;
   logic       clk = 1'b0;
   logic       rst, rg_top_start, efuse_done;
   logic [7:0] rg_settle;
   logic       efuse_load_state, afe_clk_en, slot_clk_en, data_clk_en, timer_clk_en;
   logic       shut_rstn, pmu_fifo_rstn, efuse_err;
   logic [2:0] pmu_state;
   logic [7:0] w_outs;
   int         errors = 0;
   int         checks = 0;
   always #5 clk = ~clk;
   pmu_seq dut (
      .clk              (clk),
      .rst              (rst),
      .rg_top_start     (rg_top_start),
      .rg_settle        (rg_settle),
      .efuse_done       (efuse_done),
      .efuse_load_state (efuse_load_state),
      .afe_clk_en       (afe_clk_en),
      .slot_clk_en      (slot_clk_en),
      .data_clk_en      (data_clk_en),
      .timer_clk_en     (timer_clk_en),
      .shut_rstn        (shut_rstn),
      .pmu_fifo_rstn    (pmu_fifo_rstn),
      .efuse_err        (efuse_err),
      .pmu_state        (pmu_state)
   );
   // {load, afe, slot, data, timer, shut_rstn, fifo_rstn, err}
   assign w_outs = {efuse_load_state, afe_clk_en, slot_clk_en, data_clk_en,
                    timer_clk_en, shut_rstn, pmu_fifo_rstn, efuse_err};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      rst = 1'b1; rg_top_start = 1'b0; efuse_done = 1'b0; rg_settle = 8'd0;
      step(2);
      chk("rst_state", pmu_state, 0);
      chk("rst_outs", w_outs, 8'b1000_0000);
      rst = 1'b0;
      step(10);
      chk("efuse_wait_state", pmu_state, 0);
      chk("efuse_wait_load", efuse_load_state, 1);
      efuse_done = 1'b1;
      step(1);
      efuse_done = 1'b0;
      chk("efuse_done_state", pmu_state, 1);
      chk("efuse_done_outs", w_outs, 8'b0000_0000);
      rg_settle = 8'd5; rg_top_start = 1'b1;
      step(1);
      chk("pwrup5_c1_state", pmu_state, 2);
      chk("pwrup5_c1_outs", w_outs, 8'b0100_0100);
      step(5);
      chk("pwrup5_c6_state", pmu_state, 2);
      chk("pwrup5_c6_outs", w_outs, 8'b0100_0100);
      step(1);
      chk("run5_c7_state", pmu_state, 3);
      chk("run5_c7_outs", w_outs, 8'b0111_1110);
      rg_top_start = 1'b0;
      step(1);
      chk("dn_c1_state", pmu_state, 4);
      chk("dn_c1_outs", w_outs, 8'b0100_0100);
      step(1);
      chk("dn_c2_outs", w_outs, 8'b0100_0100);
      rg_top_start = 1'b1;
      step(1);
      chk("dn_c3_state", pmu_state, 4);
      chk("dn_c3_outs", w_outs, 8'b0000_0100);
      step(1);
      chk("dn_c4_state", pmu_state, 1);
      chk("dn_c4_outs", w_outs, 8'b0000_0000);
      step(1);
      chk("restart_state", pmu_state, 2);
      chk("restart_outs", w_outs, 8'b0100_0100);
      rg_top_start = 1'b0;
      step(1);
      chk("pwrup_abort_state", pmu_state, 4);
      chk("pwrup_abort_outs", w_outs, 8'b0100_0100);
      step(3);
      chk("pwrup_abort_stby", pmu_state, 1);
      rg_settle = 8'd0; rg_top_start = 1'b1;
      step(1);
      chk("pwrup0_c1_state", pmu_state, 2);
      step(1);
      chk("run0_c2_state", pmu_state, 3);
      chk("run0_c2_outs", w_outs, 8'b0111_1110);
      rst = 1'b1;
      step(1);
      chk("midrst_state", pmu_state, 0);
      chk("midrst_outs", w_outs, 8'b1000_0000);
      rg_top_start = 1'b0; rst = 1'b0;
      step(63);
      chk("tmo_c63_state", pmu_state, 0);
      step(1);
      chk("tmo_c64_state", pmu_state, 1);
      chk("tmo_c64_outs", w_outs, 8'b0000_0001);
      rg_settle = 8'd1; rg_top_start = 1'b1;
      step(1);
      chk("tmo_pwrup_outs", w_outs, 8'b0100_0101);
      step(2);
      chk("tmo_run_state", pmu_state, 3);
      chk("tmo_run_outs", w_outs, 8'b0111_1111);
      efuse_done = 1'b1;
      step(1);
      efuse_done = 1'b0;
      chk("done_ignored_state", pmu_state, 3);
      chk("done_ignored_outs", w_outs, 8'b0111_1111);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
